// File: rtl/core_if_pkg.sv
// Shared constants, state encodings and the fetch entry type for the fetch stage.
// Optional feature macro: CORE_IF_ALIGN_CHECK_EN (see core_if.sv).
package core_if_pkg;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INST  = 32'h0000_0013;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  localparam logic [1:0] IF_FETCH = 2'd0;
  localparam logic [1:0] IF_KILL  = 2'd1;
  localparam logic [1:0] IF_STALL = 2'd2;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
  } fetch_t;

  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/core_if_if.sv
// Bundle of the fetch stage's memory, redirect/hold and IF/ID signals.
// The misalign flag exists only when CORE_IF_ALIGN_CHECK_EN is defined.
interface core_if_if;
  logic        hold_in;
  logic        jump_en_in;
  logic [31:0] jump_addr_in;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic        imem_ack_in;
  logic [31:0] imem_data_in;
  logic [31:0] inst_out;
  logic [31:0] inst_addr_out;
  logic        inst_valid_out;
`ifdef CORE_IF_ALIGN_CHECK_EN
  logic        inst_misalign_out;
`endif

  modport master (
    input  hold_in, jump_en_in, jump_addr_in, imem_ack_in, imem_data_in,
    output imem_req_out, imem_addr_out, inst_out, inst_addr_out, inst_valid_out
`ifdef CORE_IF_ALIGN_CHECK_EN
    , output inst_misalign_out
`endif
  );

  modport slave (
    output hold_in, jump_en_in, jump_addr_in, imem_ack_in, imem_data_in,
    input  imem_req_out, imem_addr_out, inst_out, inst_addr_out, inst_valid_out
`ifdef CORE_IF_ALIGN_CHECK_EN
    , input inst_misalign_out
`endif
  );
endinterface

// File: rtl/core_if_skid.sv
// One-entry instruction/address buffer that catches a fetch arriving while IF/ID is held.
// Clear wins over load. Independent of CORE_IF_ALIGN_CHECK_EN.
module core_if_skid
  import core_if_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   clear,
  input  fetch_t din,
  output logic   valid,
  output fetch_t dout
);

  logic   valid_reg;
  fetch_t entry_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_reg <= 1'b0;
      entry_reg <= '{inst: ZERO_WORD, addr: ZERO_WORD};
    end else if (clear) begin
      valid_reg <= 1'b0;
    end else if (load) begin
      valid_reg <= 1'b1;
      entry_reg <= din;
    end
  end

  assign valid = valid_reg;
  assign dout  = entry_reg;

endmodule

// File: rtl/core_if.sv
// Instruction fetch stage: pc, imem req/ack FSM, redirect kill and IF/ID register.
// Define CORE_IF_ALIGN_CHECK_EN to trap misaligned jump targets instead of masking them.
module core_if
  import core_if_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  core_if_if.master bus
);

  logic [1:0]  state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] addr_reg, addr_next;
  fetch_t      id_reg, id_next;
  logic        valid_reg, valid_next;
  logic        run_reg;
  logic        halt_reg;
  logic        req, ack;
  logic [31:0] target;
  logic        load_id;
  fetch_t      load_val;
  logic        skid_load, skid_clear, skid_valid;
  fetch_t      skid_entry;

`ifdef CORE_IF_ALIGN_CHECK_EN
  logic halt_next, mis_reg, mis_next, bad_jump;
  assign bad_jump = |bus.jump_addr_in[1:0];
  assign target   = bus.jump_addr_in;
`else
  assign halt_reg = 1'b0;
  assign target   = bus.jump_addr_in & ~32'h3;
`endif

  // run_reg keeps the request low for the first cycle out of reset
  assign req = run_reg && (((state_reg == IF_FETCH) && !halt_reg) || (state_reg == IF_KILL));
  assign ack = req && bus.imem_ack_in;

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    addr_next  = addr_reg;
    id_next    = id_reg;
    valid_next = valid_reg;
    load_id    = 1'b0;
    load_val   = '{inst: bus.imem_data_in, addr: pc_reg};
    skid_load  = 1'b0;
    skid_clear = 1'b0;
`ifdef CORE_IF_ALIGN_CHECK_EN
    halt_next  = halt_reg;
    mis_next   = mis_reg;
`endif
    // an unheld IF/ID with nothing new to take becomes a bubble
    if (!bus.hold_in) begin
      id_next    = '{inst: NOP_INST, addr: ZERO_WORD};
      valid_next = 1'b0;
`ifdef CORE_IF_ALIGN_CHECK_EN
      mis_next   = 1'b0;
`endif
    end

    if (bus.jump_en_in) begin
      skid_clear = 1'b1;
      pc_next    = target;
      id_next    = '{inst: NOP_INST, addr: ZERO_WORD};
      valid_next = 1'b0;
`ifdef CORE_IF_ALIGN_CHECK_EN
      halt_next  = 1'b0;
      mis_next   = 1'b0;
      if (bad_jump) begin
        id_next.addr = bus.jump_addr_in;
        valid_next   = 1'b1;
        mis_next     = 1'b1;
        halt_next    = 1'b1;
      end
`endif
      if ((state_reg == IF_KILL) || (req && !ack)) begin
        state_next = IF_KILL;
      end else begin
        state_next = IF_FETCH;
        addr_next  = target;
      end
    end else begin
      case (state_reg)
        IF_FETCH: begin
          if (ack) begin
            pc_next   = next_pc(pc_reg);
            addr_next = next_pc(pc_reg);
            if (!valid_reg || !bus.hold_in) begin
              load_id = 1'b1;
            end else begin
              skid_load  = 1'b1;
              state_next = IF_STALL;
            end
          end
        end
        IF_STALL: begin
          if (!bus.hold_in && skid_valid) begin
            load_id    = 1'b1;
            load_val   = skid_entry;
            skid_clear = 1'b1;
            state_next = IF_FETCH;
          end
        end
        IF_KILL: begin
          if (ack) begin
            state_next = IF_FETCH;
            addr_next  = pc_reg;
          end
        end
        default: state_next = IF_FETCH;
      endcase
    end

    if (load_id) begin
      id_next    = load_val;
      valid_next = 1'b1;
`ifdef CORE_IF_ALIGN_CHECK_EN
      mis_next   = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IF_FETCH;
      pc_reg    <= RESET_PC;
      addr_reg  <= RESET_PC;
      id_reg    <= '{inst: NOP_INST, addr: ZERO_WORD};
      valid_reg <= 1'b0;
      run_reg   <= 1'b0;
`ifdef CORE_IF_ALIGN_CHECK_EN
      halt_reg  <= 1'b0;
      mis_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      addr_reg  <= addr_next;
      id_reg    <= id_next;
      valid_reg <= valid_next;
      run_reg   <= 1'b1;
`ifdef CORE_IF_ALIGN_CHECK_EN
      halt_reg  <= halt_next;
      mis_reg   <= mis_next;
`endif
    end
  end

  core_if_skid u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .clear (skid_clear),
    .din   ('{inst: bus.imem_data_in, addr: pc_reg}),
    .valid (skid_valid),
    .dout  (skid_entry)
  );

  assign bus.imem_req_out   = req;
  assign bus.imem_addr_out  = addr_reg;
  assign bus.inst_out       = id_reg.inst;
  assign bus.inst_addr_out  = id_reg.addr;
  assign bus.inst_valid_out = valid_reg;
`ifdef CORE_IF_ALIGN_CHECK_EN
  assign bus.inst_misalign_out = mis_reg;
`endif

endmodule
